// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the parametrised register file: state encoding,
// default geometry and the byte-merge used by both the write and bypass paths.
package reg_file_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int DEPTH      = 2 ** ADDR_W_DEF;
    localparam int BE_W       = DATA_W_DEF / 8;

    // Widest register the shared merge helper handles; instances zero-extend into it.
    localparam int MAX_DATA_W = 256;
    localparam int MAX_BE_W   = MAX_DATA_W / 8;

    typedef enum logic [0:0] {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } rf_state_e;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    function automatic int be_w_of(input int data_w);
        return data_w / 8;
    endfunction

    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0] nw,
        input logic [MAX_BE_W-1:0]   be,
        input logic [MAX_DATA_W-1:0] old
    );
        logic [MAX_DATA_W-1:0] res;
        res = old;
        for (int i = 0; i < MAX_BE_W; i++) begin
            if (be[i]) res[8*i +: 8] = nw[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/reg_file_param_if.sv
// Bus bundle between decode/writeback and the register file.
interface reg_file_param_if
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2
);

    // Handshake: wr_en is a single-cycle strobe with no ready; the file either
    // commits the write at the edge or reports its loss with wr_drop one cycle
    // later. busy=1 means writes are refused and every read port returns 0.
    logic                         clear;
    logic                         busy;
    logic                         wr_en;
    logic [ADDR_W-1:0]            wr_addr;
    logic [DATA_W-1:0]            wr_data;
    logic [be_w_of(DATA_W)-1:0]   wr_be;
    logic                         wr_drop;
    logic [NUM_RD*ADDR_W-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0]     rd_data;

    modport master (
        output clear, wr_en, wr_addr, wr_data, wr_be, rd_addr,
        input  busy, wr_drop, rd_data
    );

    modport slave (
        input  clear, wr_en, wr_addr, wr_data, wr_be, rd_addr,
        output busy, wr_drop, rd_data
    );

endinterface

// File: rtl/reg_file_param.sv
// Multi-port register file with byte enables, write bypass, optional zero
// register and a sequential sweep that zeroes the array after reset or clear.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    reg_file_param_if.slave   bus,
    output rf_state_e         dbg_state_o,
    output logic [ADDR_W-1:0] dbg_sweep_cnt_o
);

    localparam int              N_ENT    = depth_of(ADDR_W);
    localparam int              N_BE     = be_w_of(DATA_W);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_ENT - 1);

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] sweep_cnt_q, sweep_cnt_d;
    logic              wr_drop_q, wr_drop_d;

    logic [DATA_W-1:0] mem [N_ENT];

    logic              sweeping;
    logic              wr_zero_hit;
    logic              wr_accept;
    logic [DATA_W-1:0] wr_merged;
    logic [DATA_W-1:0] rd_arr [NUM_RD];

    function automatic logic [DATA_W-1:0] merge(
        input logic [DATA_W-1:0] nw,
        input logic [N_BE-1:0]   be,
        input logic [DATA_W-1:0] old
    );
        return DATA_W'(byte_merge(MAX_DATA_W'(nw), MAX_BE_W'(be), MAX_DATA_W'(old)));
    endfunction

    assign sweeping    = (state_q == SWEEP);
    assign wr_zero_hit = (ZERO_REG != 0) && (bus.wr_addr == '0);
    assign wr_accept   = bus.wr_en && !sweeping && !bus.clear && !wr_zero_hit;
    assign wr_merged   = merge(bus.wr_data, bus.wr_be, mem[bus.wr_addr]);
    assign wr_drop_d   = bus.wr_en && (sweeping || bus.clear);

    always_comb begin
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        if (bus.clear) begin
            state_d     = SWEEP;
            sweep_cnt_d = '0;
        end else if (sweeping) begin
            if (sweep_cnt_q == LAST_IDX) begin
                state_d     = IDLE;
                sweep_cnt_d = '0;
            end else begin
                sweep_cnt_d = sweep_cnt_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SWEEP;
            sweep_cnt_q <= '0;
            wr_drop_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_cnt_q <= sweep_cnt_d;
            wr_drop_q   <= wr_drop_d;
        end
    end

    // No reset on the array: while rst_n is low the FSM sits in SWEEP, so the
    // only write that can happen is a harmless zero and user writes are lost.
    always_ff @(posedge clk) begin
        if (sweeping) begin
            mem[sweep_cnt_q] <= '0;
        end else if (wr_accept) begin
            mem[bus.wr_addr] <= wr_merged;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] raddr;
        logic [DATA_W-1:0] stored;
        logic [DATA_W-1:0] rdata;

        assign raddr  = bus.rd_addr[k*ADDR_W +: ADDR_W];
        assign stored = mem[raddr];

        always_comb begin
            rdata = stored;
            if (sweeping) begin
                rdata = '0;
            end else if ((ZERO_REG != 0) && (raddr == '0)) begin
                rdata = '0;
            end else if ((BYPASS != 0) && wr_accept && (bus.wr_addr == raddr)) begin
                rdata = merge(bus.wr_data, bus.wr_be, stored);
            end
        end

        assign rd_arr[k] = rdata;
    end

    always_comb begin
        bus.rd_data = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            bus.rd_data[k*DATA_W +: DATA_W] = rd_arr[k];
        end
    end

    assign bus.busy        = sweeping;
    assign bus.wr_drop     = wr_drop_q;
    assign dbg_state_o     = state_q;
    assign dbg_sweep_cnt_o = sweep_cnt_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: two instances (defaults, and ZERO_REG=0/BYPASS=0)
// driven in lockstep and compared every cycle against a countdown/array model.
module tb_reg_file_param;
  import reg_file_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        clear;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [9:0]  rd_addr;

  reg_file_param_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) if0 ();
  reg_file_param_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) if1 ();

  assign if0.clear = clear;   assign if1.clear = clear;
  assign if0.wr_en = wr_en;   assign if1.wr_en = wr_en;
  assign if0.wr_addr = wr_addr; assign if1.wr_addr = wr_addr;
  assign if0.wr_data = wr_data; assign if1.wr_data = wr_data;
  assign if0.wr_be = wr_be;   assign if1.wr_be = wr_be;
  assign if0.rd_addr = rd_addr; assign if1.rd_addr = rd_addr;

  rf_state_e  st0, st1;
  logic [4:0] cnt0, cnt1;

  reg_file_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0), .dbg_state_o(st0), .dbg_sweep_cnt_o(cnt0)
  );
  reg_file_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1), .dbg_state_o(st1), .dbg_sweep_cnt_o(cnt1)
  );

  logic [31:0] u0_p0, u0_p1, u1_p0, u1_p1;
  assign u0_p0 = if0.rd_data[31:0];
  assign u0_p1 = if0.rd_data[63:32];
  assign u1_p0 = if1.rd_data[31:0];
  assign u1_p1 = if1.rd_data[63:32];

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_rem = cycles of busy left; array contents are zero from the moment a
  // sweep is requested, since nothing is visible until the sweep ends.
  int          m_rem = DEPTH;
  logic        m_drop = 1'b0;
  logic [31:0] m_mem0 [DEPTH];
  logic [31:0] m_mem1 [DEPTH];

  function automatic logic [31:0] t_merge(input logic [31:0] nw, input logic [3:0] be,
                                          input logic [31:0] old);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < BE_W; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic bit accepted(input bit zr);
    return wr_en && (m_rem == 0) && !clear && !(zr && (wr_addr == 5'd0));
  endfunction

  function automatic logic [31:0] exp_rd(input bit zr_byp, input logic [4:0] a,
                                         input logic [31:0] stored);
    if (m_rem > 0) return 32'd0;
    if (zr_byp && a == 5'd0) return 32'd0;
    if (zr_byp && accepted(1'b1) && a == wr_addr) return t_merge(wr_data, wr_be, stored);
    return stored;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem  = DEPTH;
      m_drop = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin m_mem0[i] = '0; m_mem1[i] = '0; end
    end else begin
      m_drop = wr_en && (m_rem > 0 || clear);
      if (accepted(1'b1)) m_mem0[wr_addr] = t_merge(wr_data, wr_be, m_mem0[wr_addr]);
      if (accepted(1'b0)) m_mem1[wr_addr] = t_merge(wr_data, wr_be, m_mem1[wr_addr]);
      if (clear) begin
        m_rem = DEPTH;
        for (int i = 0; i < DEPTH; i++) begin m_mem0[i] = '0; m_mem1[i] = '0; end
      end else if (m_rem > 0) begin
        m_rem = m_rem - 1;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!done) begin
      logic [4:0] a0, a1;
      a0 = rd_addr[4:0];
      a1 = rd_addr[9:5];
      chk("busy0", 32'(if0.busy), 32'(m_rem > 0));
      chk("busy1", 32'(if1.busy), 32'(m_rem > 0));
      chk("drop0", 32'(if0.wr_drop), 32'(m_drop));
      chk("drop1", 32'(if1.wr_drop), 32'(m_drop));
      chk("u0_rd0", u0_p0, exp_rd(1'b1, a0, m_mem0[a0]));
      chk("u0_rd1", u0_p1, exp_rd(1'b1, a1, m_mem0[a1]));
      chk("u1_rd0", u1_p0, exp_rd(1'b0, a0, m_mem1[a0]));
      chk("u1_rd1", u1_p1, exp_rd(1'b0, a1, m_mem1[a1]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input bit en, input logic [4:0] a, input logic [31:0] d,
                        input logic [3:0] be);
    wr_en = en; wr_addr = a; wr_data = d; wr_be = be;
  endtask

  // Count edges after rst_n release until busy drops (bounded).
  task automatic count_release(input string name, output int n);
    n = 0;
    while (n < 100) begin
      tick();
      n++;
      @(negedge clk);
      if (!if0.busy) break;
    end
    chk(name, 32'(n), 32'd32);
  endtask

  // Count busy cycles after a clear edge; first cycle also checks wr_drop.
  task automatic count_busy(input string name, input bit exp_drop);
    int n;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (n == 0) chk({name, "_drop"}, 32'(if0.wr_drop), 32'(exp_drop));
      if (!if0.busy) break;
      n++;
      tick();
    end
    chk(name, 32'(n), 32'd32);
  endtask

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [4:0]  r0;
    logic [4:0]  r1;
  } vec_t;

  vec_t vecs [6] = '{
    '{5'd3,  32'h0000_00FF, 4'b0001, 5'd3,  5'd4},
    '{5'd4,  32'hDEAD_BEEF, 4'b1100, 5'd3,  5'd4},
    '{5'd3,  32'h1234_5678, 4'b1010, 5'd3,  5'd3},
    '{5'd31, 32'hCAFE_F00D, 4'b1111, 5'd31, 5'd0},
    '{5'd4,  32'h0BAD_F00D, 4'b0011, 5'd4,  5'd31},
    '{5'd0,  32'h8765_4321, 4'b1111, 5'd0,  5'd4}
  };

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    rst_n = 1'b1; clear = 1'b0; rd_addr = '0;
    set_wr(1'b0, 5'd0, 32'd0, 4'h0);
    #2 rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy", 32'(if0.busy), 32'd1);
    chk("rst_drop", 32'(if0.wr_drop), 32'd0);
    chk("rst_rd", u0_p0, 32'd0);

    // Reset release; a write attempted during the sweep must be dropped.
    tick();
    rst_n = 1'b1;
    n = 0;
    while (n < 100) begin
      tick();
      n++;
      set_wr(n == 5, 5'd10, 32'd1025, 4'hF);
      @(negedge clk);
      if (n == 6) chk("sweep_drop", 32'(if0.wr_drop), 32'd1);
      if (!if0.busy) break;
    end
    chk("rel_busy_edges", 32'(n), 32'd32);
    chk("state_idle", 32'(st0), 32'(IDLE));

    tick();
    rd_addr = {5'd10, 5'd10};
    @(negedge clk);
    chk("reg10_swept", u0_p0, 32'd0);
    for (int a = 0; a < DEPTH; a++) begin
      tick();
      rd_addr = {5'(DEPTH - 1 - a), 5'(a)};
    end

    // Full write with same-cycle bypass on port 1.
    tick();
    set_wr(1'b1, 5'd10, 32'd1025, 4'hF);
    rd_addr = {5'd10, 5'd3};
    @(negedge clk);
    chk("byp_p1", u0_p1, 32'd1025);
    chk("byp_other_p0", u0_p0, 32'd0);
    chk("nobyp_p1", u1_p1, 32'd0);
    tick();
    set_wr(1'b0, 5'd0, 32'd0, 4'h0);
    rd_addr = {5'd3, 5'd10};
    @(negedge clk);
    chk("wr10_u0", u0_p0, 32'd1025);
    chk("wr10_u1", u1_p0, 32'd1025);

    // Partial write.
    tick();
    set_wr(1'b1, 5'd9, 32'hAABB_CCDD, 4'hF);
    tick();
    set_wr(1'b1, 5'd9, 32'h1122_3344, 4'b0101);
    rd_addr = {5'd9, 5'd9};
    @(negedge clk);
    chk("pbyp_p0", u0_p0, 32'hAA22_CC44);
    chk("pbyp_p1", u0_p1, 32'hAA22_CC44);
    chk("pnobyp", u1_p0, 32'hAABB_CCDD);
    tick();
    set_wr(1'b0, 5'd0, 32'd0, 4'h0);
    @(negedge clk);
    chk("part_u0", u0_p0, 32'hAA22_CC44);
    chk("part_u1", u1_p0, 32'hAA22_CC44);

    // Zero register.
    tick();
    set_wr(1'b1, 5'd0, 32'hFFFF_FFFF, 4'hF);
    rd_addr = {5'd0, 5'd0};
    @(negedge clk);
    chk("zero_byp", u0_p0, 32'd0);
    tick();
    set_wr(1'b0, 5'd0, 32'd0, 4'h0);
    @(negedge clk);
    chk("zero_nodrop", 32'(if0.wr_drop), 32'd0);
    chk("zero_u0", u0_p0, 32'd0);
    chk("zero_u1", u1_p0, 32'hFFFF_FFFF);

    // Table of byte-enable writes with crossing reads.
    foreach (vecs[i]) begin
      tick();
      set_wr(1'b1, vecs[i].a, vecs[i].d, vecs[i].be);
      rd_addr = {vecs[i].r1, vecs[i].r0};
    end
    tick();
    set_wr(1'b0, 5'd0, 32'd0, 4'h0);
    rd_addr = {5'd4, 5'd3};
    @(negedge clk);
    chk("vec_r3", u0_p0, 32'h1200_56FF);
    chk("vec_r4", u0_p1, 32'hDEAD_F00D);

    // clear together with a write to reg 11.
    tick();
    clear = 1'b1;
    set_wr(1'b1, 5'd11, 32'h5A5A_5A5A, 4'hF);
    rd_addr = {5'd11, 5'd9};
    @(negedge clk);
    chk("clr_pre_busy", 32'(if0.busy), 32'd0);
    tick();
    clear = 1'b0;
    set_wr(1'b0, 5'd0, 32'd0, 4'h0);
    count_busy("clr_busy", 1'b1);
    tick();
    rd_addr = {5'd10, 5'd9};
    @(negedge clk);
    chk("clr_r9", u0_p0, 32'd0);
    chk("clr_r10", u0_p1, 32'd0);
    tick();
    rd_addr = {5'd11, 5'd11};
    @(negedge clk);
    chk("clr_r11", u0_p0, 32'd0);

    // Retrigger mid-sweep extends busy by a full DEPTH.
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (10) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    count_busy("retrig_busy", 1'b0);

    // Reset pulsed mid-sweep at sweep_cnt=15, with a write pending.
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (15) tick();
    @(negedge clk);
    chk("cnt15", 32'(cnt0), 32'd15);
    #2 rst_n = 1'b0;
    set_wr(1'b1, 5'd12, 32'h0F0F_0F0F, 4'hF);
    @(negedge clk);
    chk("mid_rst_busy", 32'(if0.busy), 32'd1);
    chk("mid_rst_cnt", 32'(cnt0), 32'd0);
    tick();
    tick();
    set_wr(1'b0, 5'd0, 32'd0, 4'h0);
    rst_n = 1'b1;
    count_release("rst_busy_edges", n);
    tick();
    rd_addr = {5'd12, 5'd12};
    @(negedge clk);
    chk("r12_lost", u0_p0, 32'd0);

    tick();
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
